// File: rtl/conv_window_scheduler_pkg.sv
// Shared codes for the conv/pool window schedulers.
// Loader slice modes, FSM states and default sizes.
package conv_window_scheduler_pkg;

  localparam int DEF_KSW   = 4;
  localparam int DEF_MAX_K = 7;
  localparam int DEF_WAW   = 6;
  localparam int DEF_TMO   = 1024;

  typedef enum logic [1:0] {
    LD_FULL    = 2'd0,
    LD_SHIFT_X = 2'd1,
    LD_SHIFT_Y = 2'd2
  } ld_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_DRAIN,
    S_WAIT,
    S_FIN
  } state_e;

endpackage

// File: rtl/conv_window_scheduler_snake.sv
// Snake-order KxK kernel walker: kx/ky, row direction,
// last-window flag and the move that produced the current window.
module kernel_snake_counter
  import conv_window_scheduler_pkg::*;
#(
  parameter int KW = DEF_KSW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  input  logic [KW-1:0] k,
  output logic [KW-1:0] kx,
  output logic [KW-1:0] ky,
  output logic          last,
  output ld_mode_e      mv
);

  logic          rev;
  logic          row_end;
  logic [KW-1:0] k_m1;

  assign k_m1    = k - KW'(1);
  assign row_end = rev ? (kx == '0) : (kx == k_m1);
  assign last    = row_end && (ky == k_m1);

  // At a row end kx holds and the walk turns around.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kx  <= '0;
      ky  <= '0;
      rev <= 1'b0;
      mv  <= LD_FULL;
    end else if (clr) begin
      kx  <= '0;
      ky  <= '0;
      rev <= 1'b0;
      mv  <= LD_FULL;
    end else if (step) begin
      if (row_end) begin
        ky  <= ky + KW'(1);
        rev <= !rev;
        mv  <= LD_SHIFT_Y;
      end else begin
        kx <= rev ? kx - KW'(1) : kx + KW'(1);
        mv <= LD_SHIFT_X;
      end
    end
  end

endmodule

// File: rtl/conv_window_scheduler.sv
// Sequences one PE-array convolution pass: clear, snake-walk
// the kernel windows, lagged weight reads, wait for result.
module conv_window_scheduler
  import conv_window_scheduler_pkg::*;
#(
  parameter int KERNEL_SIZE_WIDTH = DEF_KSW,
  parameter int MAX_K             = DEF_MAX_K,
  parameter int W_ADDR_WIDTH      = DEF_WAW,
  parameter int WAIT_TIMEOUT      = DEF_TMO
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [KERNEL_SIZE_WIDTH-1:0] cfg_kernel_size,
  input  logic [1:0]                   cfg_activation,
  input  logic                         cfg_op_type,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         ld_valid,
  output logic [1:0]                   ld_mode,
  output logic [KERNEL_SIZE_WIDTH-1:0] ld_kx,
  output logic [KERNEL_SIZE_WIDTH-1:0] ld_ky,
  output logic                         w_rd_en,
  output logic [W_ADDR_WIDTH-1:0]      w_rd_addr,
  output logic                         pe_rst,
  output logic                         pe_op_type,
  output logic [KERNEL_SIZE_WIDTH-1:0] pe_kernel_size,
  output logic [1:0]                   pe_activation,
  input  logic                         pe_result_ready
);

  localparam int KW = KERNEL_SIZE_WIDTH;
  localparam int AW = W_ADDR_WIDTH;
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q;
  logic [1:0]      act_q;
  logic            op_q;
  logic            err_q;
  logic            pe_rst_q;
  logic            w_en_q;
  logic [AW-1:0]   w_addr_q;
  logic [TW-1:0]   tmo_q;
  logic            k_bad;
  logic            tmo_hit;
  logic            snk_clr;
  logic            snk_step;
  logic            snk_last;
  ld_mode_e        snk_mv;
  logic [KW-1:0]   kx, ky;
  logic [AW-1:0]   addr;

  kernel_snake_counter #(.KW(KW)) u_snake (
    .clk  (clk),
    .rst  (rst),
    .clr  (snk_clr),
    .step (snk_step),
    .k    (k_q),
    .kx   (kx),
    .ky   (ky),
    .last (snk_last),
    .mv   (snk_mv)
  );

  assign k_bad   = (cfg_kernel_size == '0) ||
                   (cfg_kernel_size > KW'(MAX_K));
  assign tmo_hit = (tmo_q == TW'(WAIT_TIMEOUT - 1));
  assign addr    = AW'(ky) * AW'(k_q) + AW'(kx);

  always_comb begin
    state_d  = state_q;
    snk_clr  = 1'b0;
    snk_step = 1'b0;
    ld_valid = 1'b0;
    ld_mode  = LD_FULL;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = k_bad ? S_FIN : S_CLR;
      end
      S_CLR: begin
        snk_clr = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        ld_valid = 1'b1;
        ld_mode  = snk_mv;
        snk_step = !snk_last;
        if (snk_last) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_WAIT;
      S_WAIT: begin
        if (pe_result_ready || tmo_hit) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      act_q    <= '0;
      op_q     <= 1'b0;
      err_q    <= 1'b0;
      pe_rst_q <= 1'b0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      pe_rst_q <= (state_d != S_CLR);
      // Weight for a window is presented one cycle after its data.
      w_en_q   <= (state_q == S_LOAD);
      if (state_q == S_LOAD) w_addr_q <= addr;
      tmo_q    <= (state_q == S_WAIT) ? tmo_q + TW'(1) : '0;
      if (state_q == S_IDLE && start) begin
        k_q   <= cfg_kernel_size;
        act_q <= cfg_activation;
        op_q  <= cfg_op_type;
        err_q <= k_bad;
      end else if (state_q == S_WAIT && !pe_result_ready && tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FIN);
  assign err            = err_q;
  assign ld_kx          = kx;
  assign ld_ky          = ky;
  assign w_rd_en        = w_en_q;
  assign w_rd_addr      = w_addr_q;
  assign pe_rst         = pe_rst_q;
  assign pe_op_type     = op_q;
  assign pe_kernel_size = k_q;
  assign pe_activation  = act_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Randomized bench for conv_window_scheduler; expected
// window order is derived arithmetically from n, K.
module tb_conv_window_scheduler;

  localparam int KSW = 4;
  localparam int MXK = 7;
  localparam int WAW = 6;
  localparam int TMO = 1024;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [KSW-1:0] cfg_kernel_size = '0;
  logic [1:0]     cfg_activation = '0;
  logic           cfg_op_type = 1'b0;
  logic           pe_result_ready = 1'b0;
  logic           busy, done, err, ld_valid;
  logic [1:0]     ld_mode;
  logic [KSW-1:0] ld_kx, ld_ky, pe_kernel_size;
  logic           w_rd_en, pe_rst, pe_op_type;
  logic [WAW-1:0] w_rd_addr;
  logic [1:0]     pe_activation;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conv_window_scheduler #(
    .KERNEL_SIZE_WIDTH (KSW),
    .MAX_K             (MXK),
    .W_ADDR_WIDTH      (WAW),
    .WAIT_TIMEOUT      (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_kernel_size (cfg_kernel_size),
    .cfg_activation  (cfg_activation),
    .cfg_op_type     (cfg_op_type),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .ld_valid        (ld_valid),
    .ld_mode         (ld_mode),
    .ld_kx           (ld_kx),
    .ld_ky           (ld_ky),
    .w_rd_en         (w_rd_en),
    .w_rd_addr       (w_rd_addr),
    .pe_rst          (pe_rst),
    .pe_op_type      (pe_op_type),
    .pe_kernel_size  (pe_kernel_size),
    .pe_activation   (pe_activation),
    .pe_result_ready (pe_result_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // dly < 0: result_ready never comes, timeout expected.
  task automatic run_pass(input int k, input int dly, input bit hold);
    int kx, ky, c, a, pa, lim;
    logic [1:0] m;
    logic [1:0] act;
    logic       op;
    act = 2'($urandom_range(3));
    op  = 1'($urandom_range(1));
    pa  = 0;
    cfg_kernel_size = KSW'(k);
    cfg_activation  = act;
    cfg_op_type     = op;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    tests++;
    if ({busy, done, err, ld_valid, pe_rst} !== 5'b10000) begin
      fails++;
      $display("FAIL clr_k%0d: busy/done/err/ldv/pe_rst got %b want 10000",
               k, {busy, done, err, ld_valid, pe_rst});
    end
    tick();
    for (int n = 0; n < k * k; n++) begin
      ky = n / k;
      c  = n % k;
      kx = (ky % 2 == 1) ? k - 1 - c : c;
      m  = (n == 0) ? 2'd0 : ((c == 0) ? 2'd2 : 2'd1);
      a  = ky * k + kx;
      tests++;
      if ({ld_valid, ld_mode, ld_kx, ld_ky} !==
          {1'b1, m, KSW'(kx), KSW'(ky)}) begin
        fails++;
        $display("FAIL load_k%0d_n%0d: v/mode/kx/ky got %b/%0d/%0d/%0d want 1/%0d/%0d/%0d",
                 k, n, ld_valid, ld_mode, ld_kx, ld_ky, m, kx, ky);
      end
      tests++;
      if (n == 0) begin
        if (w_rd_en !== 1'b0) begin
          fails++;
          $display("FAIL wlag_k%0d_n0: w_rd_en got %b want 0", k, w_rd_en);
        end
      end else if ({w_rd_en, w_rd_addr} !== {1'b1, WAW'(pa)}) begin
        fails++;
        $display("FAIL wlag_k%0d_n%0d: en/addr got %b/%0d want 1/%0d",
                 k, n, w_rd_en, w_rd_addr, pa);
      end
      tests++;
      if ({pe_rst, busy, pe_kernel_size, pe_activation, pe_op_type} !==
          {1'b1, 1'b1, KSW'(k), act, op}) begin
        fails++;
        $display("FAIL pecfg_k%0d_n%0d: rst/busy/k/act/op got %b/%b/%0d/%0d/%b want 1/1/%0d/%0d/%b",
                 k, n, pe_rst, busy, pe_kernel_size, pe_activation,
                 pe_op_type, k, act, op);
      end
      pa = a;
      pe_result_ready = 1'($urandom_range(1));
      tick();
    end
    pe_result_ready = 1'b0;
    tests++;
    if ({ld_valid, w_rd_en, w_rd_addr, done} !==
        {1'b0, 1'b1, WAW'(pa), 1'b0}) begin
      fails++;
      $display("FAIL drain_k%0d: ldv/en/addr/done got %b/%b/%0d/%b want 0/1/%0d/0",
               k, ld_valid, w_rd_en, w_rd_addr, done, pa);
    end
    tick();
    lim = (dly < 0) ? TMO : dly + 1;
    for (int w = 0; w < lim; w++) begin
      tests++;
      if ({busy, done, ld_valid, w_rd_en} !== 4'b1000) begin
        fails++;
        $display("FAIL wait_k%0d_w%0d: busy/done/ldv/en got %b want 1000",
                 k, w, {busy, done, ld_valid, w_rd_en});
      end
      pe_result_ready = (w == dly);
      tick();
    end
    pe_result_ready = 1'b0;
    tests++;
    if ({done, busy, err, pe_rst} !== {1'b1, 1'b1, dly < 0, 1'b1}) begin
      fails++;
      $display("FAIL fin_k%0d: done/busy/err/pe_rst got %b want %b",
               k, {done, busy, err, pe_rst}, {1'b1, 1'b1, dly < 0, 1'b1});
    end
    tick();
    tests++;
    if ({done, busy, err, pe_rst} !== {1'b0, 1'b0, dly < 0, 1'b1}) begin
      fails++;
      $display("FAIL idle_k%0d: done/busy/err/pe_rst got %b want %b",
               k, {done, busy, err, pe_rst}, {1'b0, 1'b0, dly < 0, 1'b1});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    tests++;
    if ({busy, done, err, ld_valid, w_rd_en, pe_rst, w_rd_addr,
         pe_kernel_size, ld_kx, ld_ky} !== '0) begin
      fails++;
      $display("FAIL reset: b/d/e/v/w/pr got %b%b%b%b%b%b addr %0d k %0d want all 0",
               busy, done, err, ld_valid, w_rd_en, pe_rst, w_rd_addr,
               pe_kernel_size);
    end
    tick();
    rst = 1'b1;
    tick();
    tests++;
    if ({busy, pe_rst} !== 2'b01) begin
      fails++;
      $display("FAIL reset_idle: busy/pe_rst got %b want 01", {busy, pe_rst});
    end
  endtask

  task automatic test_k3();
    run_pass(3, 2, 1'b0);
  endtask

  task automatic test_k1();
    run_pass(1, 0, 1'b0);
  endtask

  task automatic test_bad_k();
    int bad [3];
    bad[0] = 0;
    bad[1] = 8;
    bad[2] = $urandom_range(15, 9);
    foreach (bad[i]) begin
      cfg_kernel_size = KSW'(bad[i]);
      start = 1'b1;
      tick();
      start = 1'b0;
      tests++;
      if ({done, busy, err, ld_valid, w_rd_en, pe_rst} !== 6'b111001) begin
        fails++;
        $display("FAIL badk%0d_fin: d/b/e/v/w/pr got %b want 111001",
                 bad[i], {done, busy, err, ld_valid, w_rd_en, pe_rst});
      end
      tick();
      tests++;
      if ({done, busy, err, ld_valid} !== 4'b0010) begin
        fails++;
        $display("FAIL badk%0d_idle: d/b/e/v got %b want 0010",
                 bad[i], {done, busy, err, ld_valid});
      end
    end
  endtask

  task automatic test_timeout();
    run_pass(2, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    cfg_kernel_size = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if ({ld_valid, ld_kx, ld_ky} !== {1'b1, 4'd1, 4'd1}) begin
      fails++;
      $display("FAIL mid_pos: v/kx/ky got %b/%0d/%0d want 1/1/1",
               ld_valid, ld_kx, ld_ky);
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({busy, done, err, ld_valid, w_rd_en, pe_rst} !== '0) begin
      fails++;
      $display("FAIL mid_reset: b/d/e/v/w/pr got %b want 000000",
               {busy, done, err, ld_valid, w_rd_en, pe_rst});
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL mid_nodone: done got %b want 0", done);
    end
    rst = 1'b1;
    tick();
    run_pass(3, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_pass(2, 3, 1'b1);
    run_pass(3, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_pass($urandom_range(MXK, 1), $urandom_range(15), 1'b0);
  endtask

  initial begin
    test_reset();
    test_k3();
    test_k1();
    test_bad_k();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
